// File: rtl/ct_mmu_sysmap_pkg.sv
// Shared constants, FSM state type and entry record for the sysmap configuration writer.
package ct_mmu_sysmap_pkg;

    localparam int SYSMAP_ENTRY_NUM  = 8;
    localparam int SYSMAP_ADDR_WIDTH = 28;
    localparam int SYSMAP_FLG_WIDTH  = 5;
    localparam int SYSMAP_IDX_WIDTH  = $clog2(SYSMAP_ENTRY_NUM);

    localparam logic [SYSMAP_ADDR_WIDTH-1:0] SYSMAP_BASE_RST = 28'hFFFFFFF;
    localparam logic [SYSMAP_FLG_WIDTH-1:0]  SYSMAP_FLG_RST  = 5'b10011;

    typedef enum logic [1:0] {
        SYSMAP_IDLE   = 2'd0,
        SYSMAP_CHECK  = 2'd1,
        SYSMAP_COMMIT = 2'd2
    } sysmap_state_e;

    typedef struct packed {
        logic [SYSMAP_ADDR_WIDTH-1:0] base;
        logic [SYSMAP_FLG_WIDTH-1:0]  flg;
        logic                         lock;
    } sysmap_entry_t;

    localparam sysmap_entry_t SYSMAP_ENTRY_RST = '{
        base: SYSMAP_BASE_RST,
        flg:  SYSMAP_FLG_RST,
        lock: 1'b0
    };

    // Flag reads are zero-extended; the top bit carries the entry lock.
    function automatic logic [SYSMAP_ADDR_WIDTH-1:0] sysmap_flg_rdata(
        input logic [SYSMAP_FLG_WIDTH-1:0] flg,
        input logic                        lock
    );
        logic [SYSMAP_ADDR_WIDTH-1:0] rdata;
        rdata = '0;
        rdata[SYSMAP_FLG_WIDTH-1:0]  = flg;
        rdata[SYSMAP_ADDR_WIDTH-1]   = lock;
        return rdata;
    endfunction

endpackage

// File: rtl/ct_mmu_sysmap_cfg_if.sv
// CSR-side request/response and commit handshake of the sysmap configuration writer.
interface ct_mmu_sysmap_cfg_if;
    import ct_mmu_sysmap_pkg::*;

    logic                         cfg_req_vld;
    logic                         cfg_req_rdy;
    logic                         cfg_req_wr;
    logic [SYSMAP_IDX_WIDTH-1:0]  cfg_req_idx;
    logic                         cfg_req_sel;
    logic [SYSMAP_ADDR_WIDTH-1:0] cfg_req_wdata;
    logic                         cfg_rsp_vld;
    logic [SYSMAP_ADDR_WIDTH-1:0] cfg_rsp_rdata;
    logic                         cfg_commit_req;
    logic                         cfg_commit_done;
    logic                         cfg_commit_err;
    logic [SYSMAP_IDX_WIDTH-1:0]  cfg_err_idx;

    modport master (
        output cfg_req_vld, cfg_req_wr, cfg_req_idx, cfg_req_sel, cfg_req_wdata, cfg_commit_req,
        input  cfg_req_rdy, cfg_rsp_vld, cfg_rsp_rdata, cfg_commit_done, cfg_commit_err, cfg_err_idx
    );

    modport slave (
        input  cfg_req_vld, cfg_req_wr, cfg_req_idx, cfg_req_sel, cfg_req_wdata, cfg_commit_req,
        output cfg_req_rdy, cfg_rsp_vld, cfg_rsp_rdata, cfg_commit_done, cfg_commit_err, cfg_err_idx
    );

endinterface

// File: rtl/ct_mmu_sysmap_cfg_entry.sv
// One sysmap region: software-visible shadow record plus the active copy seen by the MMU.
// Optional SYSMAP_CFG_LOCK_EN: a flag write with wdata[27]=1 makes the entry read-only until reset.
module ct_mmu_sysmap_cfg_entry
    import ct_mmu_sysmap_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic                         wr_sel,
    input  logic [SYSMAP_ADDR_WIDTH-1:0] wdata,
    input  logic                         commit_en,
    output sysmap_entry_t                shadow,
    output logic [SYSMAP_ADDR_WIDTH-1:0] active_base,
    output logic [SYSMAP_FLG_WIDTH-1:0]  active_flg
);

    sysmap_entry_t                shadow_q, shadow_d;
    logic [SYSMAP_ADDR_WIDTH-1:0] active_base_q, active_base_d;
    logic [SYSMAP_FLG_WIDTH-1:0]  active_flg_q, active_flg_d;

    always_comb begin
        shadow_d      = shadow_q;
        active_base_d = active_base_q;
        active_flg_d  = active_flg_q;
        // A locked entry still completes the handshake; the data is simply dropped.
        if (wr_en && !shadow_q.lock) begin
            if (wr_sel) begin
                shadow_d.flg = wdata[SYSMAP_FLG_WIDTH-1:0];
`ifdef SYSMAP_CFG_LOCK_EN
                shadow_d.lock = wdata[SYSMAP_ADDR_WIDTH-1];
`endif
            end else begin
                shadow_d.base = wdata;
            end
        end
        if (commit_en) begin
            active_base_d = shadow_q.base;
            active_flg_d  = shadow_q.flg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q      <= SYSMAP_ENTRY_RST;
            active_base_q <= SYSMAP_BASE_RST;
            active_flg_q  <= SYSMAP_FLG_RST;
        end else begin
            shadow_q      <= shadow_d;
            active_base_q <= active_base_d;
            active_flg_q  <= active_flg_d;
        end
    end

    assign shadow      = shadow_q;
    assign active_base = active_base_q;
    assign active_flg  = active_flg_q;

endmodule

// File: rtl/ct_mmu_sysmap_cfg.sv
// Sysmap configuration writer: CSR access to shadow entries, ordered-bound validation, atomic commit.
// Optional SYSMAP_CFG_LOCK_EN enables per-entry sticky lock bits (see ct_mmu_sysmap_cfg_entry).
//
//   state  | meaning
//   IDLE   | CSR requests accepted; waits for a commit command
//   CHECK  | walks k=1..7 checking shadow base[k] >= base[k-1]
//   COMMIT | copies every shadow entry into the active map in one edge
module ct_mmu_sysmap_cfg
    import ct_mmu_sysmap_pkg::*;
(
    input  logic                                          forever_cpuclk,
    input  logic                                          cpurst,
    ct_mmu_sysmap_cfg_if.slave                            csr,
    output logic [SYSMAP_ENTRY_NUM*SYSMAP_ADDR_WIDTH-1:0] sysmap_base_addr_flat,
    output logic [SYSMAP_ENTRY_NUM*SYSMAP_FLG_WIDTH-1:0]  sysmap_flg_flat,
    output logic                                          sysmap_cfg_update
);

    localparam logic [SYSMAP_IDX_WIDTH-1:0] CHK_LAST = SYSMAP_IDX_WIDTH'(SYSMAP_ENTRY_NUM - 1);

    sysmap_state_e                state_q, state_d;
    logic [SYSMAP_IDX_WIDTH-1:0]  chk_idx_q, chk_idx_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic [SYSMAP_IDX_WIDTH-1:0]  err_idx_q, err_idx_d;
    logic                         update_q, update_d;
    logic                         rsp_vld_q, rsp_vld_d;
    logic [SYSMAP_ADDR_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                         req_fire;
    logic                         commit_en;
    logic                         chk_fail;
    logic [SYSMAP_ENTRY_NUM-1:0]  wr_en;
    sysmap_entry_t                shadow_e    [SYSMAP_ENTRY_NUM];
    logic [SYSMAP_ADDR_WIDTH-1:0] active_base [SYSMAP_ENTRY_NUM];
    logic [SYSMAP_FLG_WIDTH-1:0]  active_flg  [SYSMAP_ENTRY_NUM];
    sysmap_entry_t                rd_entry;

    assign req_fire  = csr.cfg_req_vld && (state_q == SYSMAP_IDLE);
    assign commit_en = (state_q == SYSMAP_COMMIT);

    for (genvar i = 0; i < SYSMAP_ENTRY_NUM; i++) begin : g_entry
        assign wr_en[i] = req_fire && csr.cfg_req_wr &&
                          (csr.cfg_req_idx == SYSMAP_IDX_WIDTH'(i));

        ct_mmu_sysmap_cfg_entry u_entry (
            .clk         (forever_cpuclk),
            .rst         (cpurst),
            .wr_en       (wr_en[i]),
            .wr_sel      (csr.cfg_req_sel),
            .wdata       (csr.cfg_req_wdata),
            .commit_en   (commit_en),
            .shadow      (shadow_e[i]),
            .active_base (active_base[i]),
            .active_flg  (active_flg[i])
        );

        assign sysmap_base_addr_flat[i*SYSMAP_ADDR_WIDTH +: SYSMAP_ADDR_WIDTH] = active_base[i];
        assign sysmap_flg_flat[i*SYSMAP_FLG_WIDTH +: SYSMAP_FLG_WIDTH]         = active_flg[i];
    end

    // Equal neighbouring bounds are legal (empty region); only a decrease fails.
    assign chk_fail = shadow_e[chk_idx_q].base < shadow_e[chk_idx_q - 1'b1].base;
    assign rd_entry = shadow_e[csr.cfg_req_idx];

    always_comb begin
        state_d     = state_q;
        chk_idx_d   = chk_idx_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_idx_d   = err_idx_q;
        update_d    = 1'b0;
        rsp_vld_d   = req_fire && !csr.cfg_req_wr;
        rsp_rdata_d = rsp_rdata_q;

        if (rsp_vld_d) begin
            rsp_rdata_d = csr.cfg_req_sel ? sysmap_flg_rdata(rd_entry.flg, rd_entry.lock)
                                          : rd_entry.base;
        end

        unique case (state_q)
            SYSMAP_IDLE: begin
                if (csr.cfg_commit_req) begin
                    state_d   = SYSMAP_CHECK;
                    chk_idx_d = SYSMAP_IDX_WIDTH'(1);
                end
            end
            SYSMAP_CHECK: begin
                if (chk_fail) begin
                    state_d   = SYSMAP_IDLE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    err_idx_d = chk_idx_q;
                end else if (chk_idx_q == CHK_LAST) begin
                    state_d = SYSMAP_COMMIT;
                end else begin
                    chk_idx_d = chk_idx_q + 1'b1;
                end
            end
            SYSMAP_COMMIT: begin
                state_d  = SYSMAP_IDLE;
                done_d   = 1'b1;
                update_d = 1'b1;
            end
            default: begin
                state_d = SYSMAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state_q     <= SYSMAP_IDLE;
            chk_idx_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_idx_q   <= '0;
            update_q    <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            chk_idx_q   <= chk_idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_idx_q   <= err_idx_d;
            update_q    <= update_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign csr.cfg_req_rdy     = (state_q == SYSMAP_IDLE);
    assign csr.cfg_rsp_vld     = rsp_vld_q;
    assign csr.cfg_rsp_rdata   = rsp_rdata_q;
    assign csr.cfg_commit_done = done_q;
    assign csr.cfg_commit_err  = err_q;
    assign csr.cfg_err_idx     = err_idx_q;
    assign sysmap_cfg_update   = update_q;

endmodule

// File: tb/tb_ct_mmu_sysmap_cfg.sv
// Self-checking bench for ct_mmu_sysmap_cfg against an array-based model of the shadow/active map.
module tb_ct_mmu_sysmap_cfg;
    import ct_mmu_sysmap_pkg::*;

`ifdef SYSMAP_CFG_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         forever_cpuclk = 1'b0;
    logic         cpurst;
    logic [223:0] sysmap_base_addr_flat;
    logic [39:0]  sysmap_flg_flat;
    logic         sysmap_cfg_update;

    ct_mmu_sysmap_cfg_if csr();

    ct_mmu_sysmap_cfg dut (
        .forever_cpuclk        (forever_cpuclk),
        .cpurst                (cpurst),
        .csr                   (csr),
        .sysmap_base_addr_flat (sysmap_base_addr_flat),
        .sysmap_flg_flat       (sysmap_flg_flat),
        .sysmap_cfg_update     (sysmap_cfg_update)
    );

    initial forever #5 forever_cpuclk = ~forever_cpuclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_fail = 0;

    logic [27:0] m_sh_base  [8];
    logic [4:0]  m_sh_flg   [8];
    bit          m_lock     [8];
    logic [27:0] m_act_base [8];
    logic [4:0]  m_act_flg  [8];
    logic [2:0]  m_err_idx;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sh_base[i]  = 28'hFFFFFFF;
            m_sh_flg[i]   = 5'b10011;
            m_lock[i]     = 1'b0;
            m_act_base[i] = 28'hFFFFFFF;
            m_act_flg[i]  = 5'b10011;
        end
        m_err_idx = 3'd0;
    endfunction

    function automatic void model_write(input logic [2:0] idx, input bit sel, input logic [27:0] d);
        if (m_lock[idx]) return;
        if (sel) begin
            m_sh_flg[idx] = d[4:0];
            if (LOCK_EN && d[27]) m_lock[idx] = 1'b1;
        end else begin
            m_sh_base[idx] = d;
        end
    endfunction

    function automatic logic [27:0] model_read(input logic [2:0] idx, input bit sel);
        logic [27:0] r;
        if (sel) begin
            r = {23'd0, m_sh_flg[idx]};
            if (LOCK_EN && m_lock[idx]) r = r + 28'h8000000;
        end else begin
            r = m_sh_base[idx];
        end
        return r;
    endfunction

    // First index whose upper bound drops below its predecessor; 0 means the map is ordered.
    function automatic int model_first_fail();
        for (int k = 1; k < 8; k++)
            if (m_sh_base[k] < m_sh_base[k-1]) return k;
        return 0;
    endfunction

    function automatic logic [223:0] model_base_flat();
        logic [223:0] r;
        for (int i = 0; i < 8; i++) r[i*28 +: 28] = m_act_base[i];
        return r;
    endfunction

    function automatic logic [39:0] model_flg_flat();
        logic [39:0] r;
        for (int i = 0; i < 8; i++) r[i*5 +: 5] = m_act_flg[i];
        return r;
    endfunction

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic drive_idle();
        csr.cfg_req_vld    = 1'b0;
        csr.cfg_req_wr     = 1'b0;
        csr.cfg_req_idx    = 3'd0;
        csr.cfg_req_sel    = 1'b0;
        csr.cfg_req_wdata  = 28'd0;
        csr.cfg_commit_req = 1'b0;
    endtask

    task automatic wait_rdy(input string name);
        int w;
        w = 0;
        while (csr.cfg_req_rdy !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        n_chk++;
        if (w >= 50) begin
            n_fail++;
            $display("FAIL %s_rdy_timeout: rdy=%b after %0d cycles, required 1", name, csr.cfg_req_rdy, w);
        end
    endtask

    task automatic do_write(input logic [2:0] idx, input bit sel, input logic [27:0] d);
        csr.cfg_req_vld   = 1'b1;
        csr.cfg_req_wr    = 1'b1;
        csr.cfg_req_idx   = idx;
        csr.cfg_req_sel   = sel;
        csr.cfg_req_wdata = d;
        wait_rdy("write");
        tick();
        drive_idle();
        model_write(idx, sel, d);
    endtask

    task automatic do_read(input logic [2:0] idx, input bit sel);
        logic [27:0] exp;
        exp = model_read(idx, sel);
        csr.cfg_req_vld   = 1'b1;
        csr.cfg_req_wr    = 1'b0;
        csr.cfg_req_idx   = idx;
        csr.cfg_req_sel   = sel;
        csr.cfg_req_wdata = 28'($urandom);
        wait_rdy("read");
        tick();
        drive_idle();
        n_chk++;
        if (csr.cfg_rsp_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL read_rsp_vld idx=%0d sel=%0d: got %b required 1", idx, sel, csr.cfg_rsp_vld);
        end
        n_chk++;
        if (csr.cfg_rsp_rdata !== exp) begin
            n_fail++;
            $display("FAIL read_rdata idx=%0d sel=%0d: got %h required %h", idx, sel, csr.cfg_rsp_rdata, exp);
        end
        tick();
        n_chk++;
        if (csr.cfg_rsp_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp_pulse: got %b required 0", csr.cfg_rsp_vld);
        end
    endtask

    task automatic do_commit(input bit wr_same, input logic [2:0] widx, input logic [27:0] wd);
        int kf;
        int exp_n;
        wait_rdy("commit");
        csr.cfg_commit_req = 1'b1;
        if (wr_same) begin
            csr.cfg_req_vld   = 1'b1;
            csr.cfg_req_wr    = 1'b1;
            csr.cfg_req_idx   = widx;
            csr.cfg_req_sel   = 1'b0;
            csr.cfg_req_wdata = wd;
            model_write(widx, 1'b0, wd);
        end
        kf    = model_first_fail();
        exp_n = (kf == 0) ? 9 : kf + 1;
        tick();
        drive_idle();
        for (int n = 1; n <= exp_n + 1; n++) begin
            if (n == exp_n) begin
                if (kf == 0) begin
                    for (int i = 0; i < 8; i++) begin
                        m_act_base[i] = m_sh_base[i];
                        m_act_flg[i]  = m_sh_flg[i];
                    end
                end else begin
                    m_err_idx = 3'(kf);
                end
            end
            n_chk++;
            if (csr.cfg_commit_done !== (n == exp_n)) begin
                n_fail++;
                $display("FAIL commit_done T+%0d: got %b required %b", n, csr.cfg_commit_done, (n == exp_n));
            end
            n_chk++;
            if (csr.cfg_commit_err !== (n == exp_n && kf != 0)) begin
                n_fail++;
                $display("FAIL commit_err T+%0d: got %b required %b", n, csr.cfg_commit_err, (n == exp_n && kf != 0));
            end
            n_chk++;
            if (csr.cfg_err_idx !== m_err_idx) begin
                n_fail++;
                $display("FAIL err_idx T+%0d: got %0d required %0d", n, csr.cfg_err_idx, m_err_idx);
            end
            n_chk++;
            if (sysmap_cfg_update !== (n == exp_n && kf == 0)) begin
                n_fail++;
                $display("FAIL update T+%0d: got %b required %b", n, sysmap_cfg_update, (n == exp_n && kf == 0));
            end
            n_chk++;
            if (csr.cfg_req_rdy !== (n >= exp_n)) begin
                n_fail++;
                $display("FAIL commit_rdy T+%0d: got %b required %b", n, csr.cfg_req_rdy, (n >= exp_n));
            end
            n_chk++;
            if (sysmap_base_addr_flat !== model_base_flat() || sysmap_flg_flat !== model_flg_flat()) begin
                n_fail++;
                $display("FAIL commit_flat T+%0d: got %h/%h required %h/%h", n, sysmap_base_addr_flat,
                         sysmap_flg_flat, model_base_flat(), model_flg_flat());
            end
            tick();
        end
    endtask

    task automatic test_reset();
        drive_idle();
        cpurst = 1'b1;
        tick();
        tick();
        cpurst = 1'b0;
        model_reset();
        n_chk++;
        if (csr.cfg_req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b required 1", csr.cfg_req_rdy); end
        n_chk++;
        if (csr.cfg_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_vld: got %b required 0", csr.cfg_rsp_vld); end
        n_chk++;
        if (csr.cfg_rsp_rdata !== 28'd0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", csr.cfg_rsp_rdata); end
        n_chk++;
        if (csr.cfg_commit_done !== 1'b0 || csr.cfg_commit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done_err: got %b%b required 00", csr.cfg_commit_done, csr.cfg_commit_err);
        end
        n_chk++;
        if (csr.cfg_err_idx !== 3'd0) begin n_fail++; $display("FAIL reset_err_idx: got %0d required 0", csr.cfg_err_idx); end
        n_chk++;
        if (sysmap_cfg_update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b required 0", sysmap_cfg_update); end
        n_chk++;
        if (sysmap_base_addr_flat !== model_base_flat()) begin
            n_fail++;
            $display("FAIL reset_base_flat: got %h required %h", sysmap_base_addr_flat, model_base_flat());
        end
        n_chk++;
        if (sysmap_flg_flat !== model_flg_flat()) begin
            n_fail++;
            $display("FAIL reset_flg_flat: got %h required %h", sysmap_flg_flat, model_flg_flat());
        end
        do_read(3'd3, 1'b0);
        do_read(3'd6, 1'b1);
    endtask

    task automatic test_commit_pass();
        for (int i = 0; i < 8; i++) do_write(3'(i), 1'b0, 28'(32'h100 * (i + 1)));
        do_write(3'd0, 1'b1, 28'h0000003);
        do_commit(1'b0, 3'd0, 28'd0);
        n_chk++;
        if (sysmap_flg_flat[4:0] !== 5'b00011) begin
            n_fail++;
            $display("FAIL pass_flag0: got %b required 00011", sysmap_flg_flat[4:0]);
        end
    endtask

    task automatic test_commit_fail();
        do_write(3'd5, 1'b0, 28'h0000050);
        do_commit(1'b0, 3'd0, 28'd0);
        n_chk++;
        if (csr.cfg_err_idx !== 3'd5) begin
            n_fail++;
            $display("FAIL fail_err_idx: got %0d required 5", csr.cfg_err_idx);
        end
        do_write(3'd5, 1'b0, 28'h0000600);
    endtask

    task automatic test_stall();
        int n_done;
        wait_rdy("stall");
        csr.cfg_commit_req = 1'b1;
        tick();
        csr.cfg_commit_req = 1'b0;
        csr.cfg_req_vld    = 1'b1;
        csr.cfg_req_wr     = 1'b1;
        csr.cfg_req_idx    = 3'd7;
        csr.cfg_req_sel    = 1'b0;
        csr.cfg_req_wdata  = 28'h0000900;
        n_done = 0;
        for (int n = 1; n <= 12; n++) begin
            if (n == 9) begin
                for (int i = 0; i < 8; i++) begin
                    m_act_base[i] = m_sh_base[i];
                    m_act_flg[i]  = m_sh_flg[i];
                end
            end
            n_chk++;
            if (csr.cfg_req_rdy !== (n >= 9)) begin
                n_fail++;
                $display("FAIL stall_rdy T+%0d: got %b required %b", n, csr.cfg_req_rdy, (n >= 9));
            end
            n_chk++;
            if (sysmap_base_addr_flat !== model_base_flat()) begin
                n_fail++;
                $display("FAIL stall_flat T+%0d: got %h required %h", n, sysmap_base_addr_flat, model_base_flat());
            end
            if (csr.cfg_commit_done === 1'b1) n_done++;
            csr.cfg_commit_req = (n == 3);
            tick();
            if (n == 9) begin
                drive_idle();
                model_write(3'd7, 1'b0, 28'h0000900);
            end
        end
        n_chk++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL stall_done_count: got %0d required 1", n_done);
        end
        do_read(3'd7, 1'b0);
        n_chk++;
        if (sysmap_base_addr_flat[7*28 +: 28] !== m_act_base[7]) begin
            n_fail++;
            $display("FAIL stall_active7: got %h required %h", sysmap_base_addr_flat[7*28 +: 28], m_act_base[7]);
        end
    endtask

    task automatic test_same_cycle_and_reset();
        do_write(3'd7, 1'b0, 28'h0000010);
        do_commit(1'b1, 3'd7, 28'h0000A00);
        do_write(3'd7, 1'b0, 28'h0000010);
        do_write(3'd1, 1'b1, 28'h0000015);
        wait_rdy("rst_mid");
        csr.cfg_commit_req = 1'b1;
        csr.cfg_req_vld    = 1'b1;
        csr.cfg_req_wr     = 1'b1;
        csr.cfg_req_idx    = 3'd7;
        csr.cfg_req_sel    = 1'b0;
        csr.cfg_req_wdata  = 28'h0000B00;
        tick();
        drive_idle();
        tick();
        tick();
        tick();
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        model_reset();
        for (int n = 0; n < 12; n++) begin
            n_chk++;
            if (csr.cfg_commit_done !== 1'b0 || sysmap_cfg_update !== 1'b0 || csr.cfg_req_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid_pulses +%0d: done=%b update=%b rdy=%b required 0 0 1", n,
                         csr.cfg_commit_done, sysmap_cfg_update, csr.cfg_req_rdy);
            end
            n_chk++;
            if (sysmap_base_addr_flat !== model_base_flat() || sysmap_flg_flat !== model_flg_flat()) begin
                n_fail++;
                $display("FAIL rst_mid_flat +%0d: got %h/%h required %h/%h", n, sysmap_base_addr_flat,
                         sysmap_flg_flat, model_base_flat(), model_flg_flat());
            end
            tick();
        end
        n_chk++;
        if (csr.cfg_err_idx !== 3'd0) begin n_fail++; $display("FAIL rst_mid_err_idx: got %0d required 0", csr.cfg_err_idx); end
        do_read(3'd7, 1'b0);
        do_read(3'd1, 1'b1);
    endtask

    task automatic test_lock();
        do_write(3'd2, 1'b1, 28'h800000A);
        do_write(3'd2, 1'b0, 28'h0000123);
        do_read(3'd2, 1'b0);
        do_read(3'd2, 1'b1);
        do_write(3'd2, 1'b1, 28'h0000004);
        do_read(3'd2, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [27:0] exp;
        logic [27:0] prev_exp;
        for (int i = 0; i < 8; i++) begin
            exp = model_read(3'(i), i[0]);
            csr.cfg_req_vld = 1'b1;
            csr.cfg_req_wr  = 1'b0;
            csr.cfg_req_idx = 3'(i);
            csr.cfg_req_sel = i[0];
            if (i > 0) begin
                n_chk++;
                if (csr.cfg_rsp_vld !== 1'b1 || csr.cfg_rsp_rdata !== prev_exp) begin
                    n_fail++;
                    $display("FAIL b2b_read %0d: vld=%b data=%h required 1 %h", i - 1, csr.cfg_rsp_vld,
                             csr.cfg_rsp_rdata, prev_exp);
                end
            end
            prev_exp = exp;
            tick();
        end
        drive_idle();
        n_chk++;
        if (csr.cfg_rsp_vld !== 1'b1 || csr.cfg_rsp_rdata !== prev_exp) begin
            n_fail++;
            $display("FAIL b2b_read 7: vld=%b data=%h required 1 %h", csr.cfg_rsp_vld, csr.cfg_rsp_rdata, prev_exp);
        end
        tick();
        n_chk++;
        if (csr.cfg_rsp_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_end: rsp_vld=%b required 0", csr.cfg_rsp_vld); end
    endtask

    task automatic test_random();
        int op;
        logic [2:0] idx;
        bit sel;
        logic [27:0] d;
        logic [27:0] base;
        for (int it = 0; it < 60; it++) begin
            op  = $urandom_range(0, 9);
            idx = 3'($urandom_range(0, 7));
            sel = 1'($urandom_range(0, 1));
            if (op < 4) begin
                d = sel ? 28'($urandom) : 28'($urandom_range(0, 4095));
                do_write(idx, sel, d);
            end else if (op < 7) begin
                do_read(idx, sel);
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    base = 28'($urandom_range(0, 255));
                    for (int i = 0; i < 8; i++) begin
                        do_write(3'(i), 1'b0, base);
                        base = base + 28'($urandom_range(0, 64));
                    end
                end
                do_commit(1'($urandom_range(0, 1)), idx, 28'($urandom_range(0, 4095)));
            end
        end
    endtask

    initial begin
        drive_idle();
        cpurst = 1'b1;
        model_reset();
        test_reset();
        test_commit_pass();
        test_commit_fail();
        test_stall();
        test_same_cycle_and_reset();
        test_lock();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
